// File: rtl/gpr_wb_arb.sv
// GPR writeback arbiter: buffers ALU and LSU results in per-source FIFOs and issues one register write per cycle.
// Optional macro GPR_WB_FWD_EN adds same-cycle forwarding ports for the two read-stage source operands.
module gpr_wb_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int GPRS_WIDTH = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [GPRS_WIDTH-1:0] i_alu_rd_id,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic [GPRS_WIDTH-1:0] i_lsu_rd_id,
  input  logic [DATA_WIDTH-1:0] i_lsu_data,
  output logic                  o_wr_en,
  output logic [GPRS_WIDTH-1:0] o_wr_id,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_busy
`ifdef GPR_WB_FWD_EN
  ,
  input  logic [GPRS_WIDTH-1:0] i_fwd_rs1_id,
  input  logic [GPRS_WIDTH-1:0] i_fwd_rs2_id,
  output logic                  o_fwd_rs1_hit,
  output logic                  o_fwd_rs2_hit,
  output logic [DATA_WIDTH-1:0] o_fwd_rs1_data,
  output logic [DATA_WIDTH-1:0] o_fwd_rs2_data
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam int ENT_W = GPRS_WIDTH + DATA_WIDTH;

  logic [ENT_W-1:0] alu_mem [FIFO_DEPTH];
  logic [ENT_W-1:0] lsu_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] alu_wr_ptr, alu_rd_ptr, lsu_wr_ptr, lsu_rd_ptr;
  logic [CNT_W-1:0] alu_cnt, lsu_cnt;
  logic [STV_W-1:0] starve_cnt;

  logic alu_push, lsu_push, alu_ne, lsu_ne;
  logic grant_alu, grant_lsu, any_pop;
  logic [ENT_W-1:0]      pop_entry;
  logic [GPRS_WIDTH-1:0] pop_id;
  logic [DATA_WIDTH-1:0] pop_data;

  // Ready depends only on registered occupancy, so a same-cycle pop never raises it.
  assign o_alu_ready = alu_cnt < CNT_W'(FIFO_DEPTH);
  assign o_lsu_ready = lsu_cnt < CNT_W'(FIFO_DEPTH);
  assign alu_push    = i_alu_valid && o_alu_ready;
  assign lsu_push    = i_lsu_valid && o_lsu_ready;
  assign alu_ne      = alu_cnt != '0;
  assign lsu_ne      = lsu_cnt != '0;

  assign grant_lsu = lsu_ne && (!alu_ne || (starve_cnt < STV_W'(STARVE_MAX)));
  assign grant_alu = !grant_lsu && alu_ne;
  assign any_pop   = grant_lsu || grant_alu;
  assign pop_entry = grant_lsu ? lsu_mem[lsu_rd_ptr] : alu_mem[alu_rd_ptr];
  assign pop_id    = pop_entry[ENT_W-1 -: GPRS_WIDTH];
  assign pop_data  = pop_entry[DATA_WIDTH-1:0];

  assign o_busy = alu_ne || lsu_ne || o_wr_en;

  // Storage needs no reset: occupancy counters decide what is valid.
  always_ff @(posedge i_clk) begin
    if (alu_push) alu_mem[alu_wr_ptr] <= {i_alu_rd_id, i_alu_data};
    if (lsu_push) lsu_mem[lsu_wr_ptr] <= {i_lsu_rd_id, i_lsu_data};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      alu_wr_ptr <= '0;
      alu_rd_ptr <= '0;
      alu_cnt    <= '0;
    end else begin
      if (alu_push)  alu_wr_ptr <= alu_wr_ptr + PTR_W'(1);
      if (grant_alu) alu_rd_ptr <= alu_rd_ptr + PTR_W'(1);
      case ({alu_push, grant_alu})
        2'b10:   alu_cnt <= alu_cnt + CNT_W'(1);
        2'b01:   alu_cnt <= alu_cnt - CNT_W'(1);
        default: alu_cnt <= alu_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lsu_wr_ptr <= '0;
      lsu_rd_ptr <= '0;
      lsu_cnt    <= '0;
    end else begin
      if (lsu_push)  lsu_wr_ptr <= lsu_wr_ptr + PTR_W'(1);
      if (grant_lsu) lsu_rd_ptr <= lsu_rd_ptr + PTR_W'(1);
      case ({lsu_push, grant_lsu})
        2'b10:   lsu_cnt <= lsu_cnt + CNT_W'(1);
        2'b01:   lsu_cnt <= lsu_cnt - CNT_W'(1);
        default: lsu_cnt <= lsu_cnt;
      endcase
    end
  end

  // Counts LSU wins while an ALU result waits; reaching STARVE_MAX hands the port to the ALU.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (grant_alu || !alu_ne) begin
      starve_cnt <= '0;
    end else if (grant_lsu && (starve_cnt != STV_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // Register x0 is never written, but popping it still consumes the slot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_wr_en   <= 1'b0;
      o_wr_id   <= '0;
      o_wr_data <= '0;
    end else if (any_pop) begin
      o_wr_en   <= pop_id != '0;
      o_wr_id   <= pop_id;
      o_wr_data <= pop_data;
    end else begin
      o_wr_en   <= 1'b0;
    end
  end

`ifdef GPR_WB_FWD_EN
  assign o_fwd_rs1_hit  = o_wr_en && (o_wr_id == i_fwd_rs1_id) && (i_fwd_rs1_id != '0);
  assign o_fwd_rs2_hit  = o_wr_en && (o_wr_id == i_fwd_rs2_id) && (i_fwd_rs2_id != '0);
  assign o_fwd_rs1_data = o_fwd_rs1_hit ? o_wr_data : '0;
  assign o_fwd_rs2_data = o_fwd_rs2_hit ? o_wr_data : '0;
`endif

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Self-checking bench for gpr_wb_arb: directed scenarios plus randomized traffic against a queue-based model.
module tb_gpr_wb_arb;

  localparam int DW    = 32;
  localparam int GW    = 5;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, lsu_valid;
  logic [GW-1:0] alu_rd_id, lsu_rd_id;
  logic [DW-1:0] alu_data, lsu_data;
  logic          alu_ready, lsu_ready;
  logic          wr_en, busy;
  logic [GW-1:0] wr_id;
  logic [DW-1:0] wr_data;

  always #5 clk = ~clk;

  gpr_wb_arb #(.DATA_WIDTH(DW), .GPRS_WIDTH(GW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_valid(alu_valid), .o_alu_ready(alu_ready), .i_alu_rd_id(alu_rd_id), .i_alu_data(alu_data),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_rd_id(lsu_rd_id), .i_lsu_data(lsu_data),
    .o_wr_en(wr_en), .o_wr_id(wr_id), .o_wr_data(wr_data), .o_busy(busy)
  );

  typedef struct packed {
    logic [GW-1:0] id;
    logic [DW-1:0] data;
  } entry_t;

  int checks = 0;
  int failures = 0;

  // Reference model: queued results, a starvation tally and the expected write port.
  entry_t        alu_q[$];
  entry_t        lsu_q[$];
  int            starve = 0;
  logic          exp_en = 1'b0;
  logic [GW-1:0] exp_id = '0;
  logic [DW-1:0] exp_data = '0;
  logic [GW-1:0] wr_log[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic applyStimulus(input logic rst_in,
                               input logic av, input logic [GW-1:0] aid, input logic [DW-1:0] ad,
                               input logic lv, input logic [GW-1:0] lid, input logic [DW-1:0] ld,
                               output bit a_acc, output bit l_acc);
    bit     a_rdy, l_rdy, ane, lne, gl, ga;
    entry_t e;
    rst_n = rst_in;
    alu_valid = av; alu_rd_id = aid; alu_data = ad;
    lsu_valid = lv; lsu_rd_id = lid; lsu_data = ld;
    a_acc = 0;
    l_acc = 0;
    if (!rst_in) begin
      alu_q.delete();
      lsu_q.delete();
      starve = 0;
      exp_en = 1'b0;
      exp_id = '0;
      exp_data = '0;
    end else begin
      a_rdy = alu_q.size() < DEPTH;
      l_rdy = lsu_q.size() < DEPTH;
      ane = alu_q.size() != 0;
      lne = lsu_q.size() != 0;
      gl = lne && (!ane || starve < SMAX);
      ga = !gl && ane;
      if (ga || !ane) starve = 0;
      else if (gl && starve < SMAX) starve++;
      exp_en = 1'b0;
      if (gl) begin
        e = lsu_q.pop_front();
        exp_en = (e.id != 0); exp_id = e.id; exp_data = e.data;
      end else if (ga) begin
        e = alu_q.pop_front();
        exp_en = (e.id != 0); exp_id = e.id; exp_data = e.data;
      end
      if (av && a_rdy) begin
        e = {aid, ad};
        alu_q.push_back(e);
        a_acc = 1;
      end
      if (lv && l_rdy) begin
        e = {lid, ld};
        lsu_q.push_back(e);
        l_acc = 1;
      end
    end
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) wr_log.push_back(wr_id);
    checkOutput("wr_en", wr_en, exp_en);
    if (exp_en) begin
      checkOutput("wr_id", wr_id, exp_id);
      checkOutput("wr_data", wr_data, exp_data);
    end
    checkOutput("alu_ready", alu_ready, alu_q.size() < DEPTH);
    checkOutput("lsu_ready", lsu_ready, lsu_q.size() < DEPTH);
    checkOutput("busy", busy, (alu_q.size() != 0) || (lsu_q.size() != 0) || exp_en);
  endtask

  task automatic idleCycle(input logic rst_in);
    bit aa, la;
    applyStimulus(rst_in, 1'b0, '0, '0, 1'b0, '0, '0, aa, la);
  endtask

  initial begin
    bit            aa, la;
    bit            a_pend, l_pend;
    logic [GW-1:0] a_id, l_id;
    logic [DW-1:0] a_d, l_d;
    int            lrd;
    bit            a_p;
    int            exp_order[10] = '{1, 2, 3, 4, 7, 5, 6, 7, 8, 9};

    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd_id = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd_id = '0; lsu_data = '0;

    // Reset then idle
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_id", wr_id, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_alu_ready", alu_ready, 1);
    checkOutput("rst_lsu_ready", lsu_ready, 1);
    checkOutput("rst_busy", busy, 0);
    idleCycle(1'b1);
    checkOutput("idle_wr_en", wr_en, 0);

    // Single ALU result: written the cycle after the second edge
    applyStimulus(1'b1, 1'b1, GW'(5), 32'hDEADBEEF, 1'b0, '0, '0, aa, la);
    checkOutput("dbeef_edge1_en", wr_en, 0);
    idleCycle(1'b1);
    checkOutput("dbeef_en", wr_en, 1);
    checkOutput("dbeef_id", wr_id, 5);
    checkOutput("dbeef_data", wr_data, 32'hDEADBEEF);
    idleCycle(1'b1);
    checkOutput("dbeef_after_en", wr_en, 0);

    // Same-edge ALU and LSU: LSU written first
    applyStimulus(1'b1, 1'b1, GW'(3), 32'h11, 1'b1, GW'(4), 32'h22, aa, la);
    idleCycle(1'b1);
    checkOutput("prio_first_id", wr_id, 4);
    checkOutput("prio_first_data", wr_data, 32'h22);
    idleCycle(1'b1);
    checkOutput("prio_second_id", wr_id, 3);
    checkOutput("prio_second_en", wr_en, 1);
    idleCycle(1'b1);

    // Anti-starvation: LSU streams rd 1..9 while ALU holds rd 7
    wr_log.delete();
    lrd = 1;
    a_p = 1;
    for (int c = 0; c < 40 && wr_log.size() < 10; c++) begin
      applyStimulus(1'b1, a_p, GW'(7), 32'h77, lrd <= 9, GW'(lrd), DW'(32'h100 + lrd), aa, la);
      if (aa) a_p = 0;
      if (la) lrd++;
    end
    checkOutput("starve_write_count", wr_log.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < wr_log.size()) checkOutput("starve_order", wr_log[i], exp_order[i]);
    idleCycle(1'b1);
    idleCycle(1'b1);

    // rd 0 popped without a write, next entry written normally
    applyStimulus(1'b1, 1'b1, GW'(0), 32'hAA, 1'b0, '0, '0, aa, la);
    idleCycle(1'b1);
    checkOutput("x0_wr_en", wr_en, 0);
    checkOutput("x0_busy", busy, 0);
    applyStimulus(1'b1, 1'b1, GW'(9), 32'h99, 1'b0, '0, '0, aa, la);
    idleCycle(1'b1);
    checkOutput("after_x0_en", wr_en, 1);
    checkOutput("after_x0_id", wr_id, 9);
    checkOutput("after_x0_data", wr_data, 32'h99);
    idleCycle(1'b1);

    // Fill the LSU FIFO behind a forced ALU grant, then reset mid-flight
    lrd = 1;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, c == 0, GW'(7), 32'h77, 1'b1, GW'(lrd), DW'(32'h200 + lrd), aa, la);
      if (la) lrd++;
    end
    checkOutput("lsu_full_ready", lsu_ready, 0);
    idleCycle(1'b0);
    wr_log.delete();
    checkOutput("flush_lsu_ready", lsu_ready, 1);
    checkOutput("flush_alu_ready", alu_ready, 1);
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_wr_en", wr_en, 0);
    for (int c = 0; c < 3; c++) idleCycle(1'b1);
    checkOutput("flush_no_writes", wr_log.size(), 0);

    // Randomized traffic; sources hold their offer until accepted
    a_pend = 0; l_pend = 0;
    a_id = '0; l_id = '0; a_d = '0; l_d = '0;
    for (int c = 0; c < 1500; c++) begin
      logic r;
      if (!a_pend && $urandom_range(0, 99) < 55) begin
        a_pend = 1; a_id = GW'($urandom); a_d = $urandom;
      end
      if (!l_pend && $urandom_range(0, 99) < 45) begin
        l_pend = 1; l_id = GW'($urandom); l_d = $urandom;
      end
      r = ($urandom_range(0, 199) != 0);
      applyStimulus(r, a_pend, a_id, a_d, l_pend, l_id, l_d, aa, la);
      if (aa || !r) a_pend = 0;
      if (la || !r) l_pend = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
